bitscan_seq: RTL and testbench
==============================

BITSCAN_SEQ -- requirements
Module: bitscan_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32; operand width in bits, power of two, 32 or 64.
REQ-002 The block SHALL define IW = $clog2(WIDTH), used below as a width.
REQ-003 The block SHALL have port clk, input, 1, the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port InValid, input, 1, operand offered.
REQ-006 The block SHALL have port InReady, output, 1, block can accept an operand this cycle.
REQ-007 The block SHALL have port A, input, WIDTH, operand whose set bits are enumerated.
REQ-008 The block SHALL have port Rev, input, 1, scan MSB-first when 1 (see Configuration).
REQ-009 The block SHALL have port OutValid, output, 1, an index beat is presented.
REQ-010 The block SHALL have port OutReady, input, 1, consumer takes the beat.
REQ-011 The block SHALL have port Index, output, IW, bit position of the current set bit.
REQ-012 The block SHALL have port Count, output, IW+1, ordinal of the current beat within the operand, starting at 0.
REQ-013 The block SHALL have port Last, output, 1, current beat is the final beat for this operand.
REQ-014 The block SHALL have port Empty, output, 1, operand was all zeros.

Function
REQ-015 The block SHALL implement states IDLE and SCAN.
REQ-016 InReady SHALL equal IDLE | (SCAN & Last & OutReady); the OutReady-to-InReady combinational path is intentional.
REQ-017 On InValid & InReady at a clock edge, the block SHALL capture A into the Pending register, capture Rev, clear Count, and enter SCAN.
REQ-018 OutValid SHALL be 1 exactly when in SCAN; the first beat appears one cycle after acceptance, with no extra latency.
REQ-019 In SCAN with LSB-first, Index SHALL be the position of the lowest set bit of Pending.
REQ-020 In SCAN with MSB-first, Index SHALL be the position of the highest set bit of Pending.
REQ-021 Last SHALL be 1 when Pending holds at most one set bit.
REQ-022 Empty SHALL be 1 when Pending was zero at capture.
REQ-023 A zero operand SHALL produce exactly one beat: Empty=1, Last=1, Index=0, Count=0.
REQ-024 On OutValid & OutReady with !Last, the block SHALL clear the bit at Index in Pending and increment Count.
REQ-025 On OutValid & OutReady with Last, the block SHALL return to IDLE, unless InValid is also 1, in which case it SHALL capture the new operand and stay in SCAN.
REQ-026 While OutValid & !OutReady, Index, Count, Last and Empty SHALL hold stable.
REQ-027 An operand with all WIDTH bits set SHALL yield WIDTH beats, and Count SHALL be WIDTH-1 on the last beat.
REQ-028 InValid in SCAN without a Last handshake SHALL be ignored and not captured.
REQ-029 In IDLE, Index, Count, Last and Empty SHALL be 0.

Reset
REQ-030 Reset SHALL force IDLE, Pending=0 and Count=0 immediately, without waiting for clk.
REQ-031 In reset, InReady SHALL be 1 and OutValid SHALL be 0.
REQ-032 Reset asserted mid-scan SHALL discard remaining beats; the first post-reset operand SHALL start at Count=0.

Configuration
REQ-033 With macro BITSCAN_REVERSE_EN defined, Rev SHALL be captured per operand and select MSB-first scanning; Rev changes during SCAN SHALL have no effect.
REQ-034 Without BITSCAN_REVERSE_EN, Rev SHALL be ignored, scanning SHALL always be LSB-first, and no reverse-scan logic SHALL be built.

Verification
REQ-035 Zero operand: A=0x00000000, OutReady=1 -> one beat, Empty=1, Last=1, Index=0, Count=0, then IDLE.
REQ-036 Sparse operand: A=0x80000011, Rev=0, OutReady=1 -> Index 0,4,31 with Count 0,1,2, and Last only on 31.
REQ-037 Reverse scan: with BITSCAN_REVERSE_EN defined, A=0x80000011, Rev=1 -> Index 31,4,0; without the macro -> Index 0,4,31.
REQ-038 Backpressure: A=0x00000300, OutReady low 3 cycles -> Index=8 and Count=0 held for 3 cycles, then 8 then 9.
REQ-039 Back-to-back: second operand 0x1 presented with InValid=1 on the Last handshake of 0x2 -> accepted that edge, next beat Index=0, Count=0, with no IDLE bubble.
REQ-040 Reset mid-scan: A=0xFFFFFFFF, reset asserted after 5 beats -> OutValid=0 at once; next operand 0x4 -> Index=2, Count=0.

Source files
------------

// File: rtl/bitscan_seq.sv
// -----------------------------------------------------------------------------
// bitscan_seq
//   Enumerates the set bits of an operand, one index beat per handshake.
//   An accepted operand is held in the Pending register; each consumed beat
//   clears the reported bit and advances Count until the final set bit (Last)
//   is taken. An all-zero operand produces a single beat flagged Empty.
//
// Configuration macro:
//   BITSCAN_REVERSE_EN  when defined, Rev is captured with each operand and
//                       selects MSB-first scanning. When undefined, Rev is
//                       ignored, scanning is LSB-first and no reverse-scan
//                       logic is built.
//
// Ports:
//   clk       in   clock, rising edge
//   reset     in   asynchronous active-high reset
//   InValid   in   operand offered
//   InReady   out  operand can be accepted this cycle
//   A         in   [WIDTH-1:0] operand
//   Rev       in   scan MSB-first (only with BITSCAN_REVERSE_EN)
//   OutValid  out  an index beat is presented
//   OutReady  in   consumer takes the beat
//   Index     out  [IW-1:0] position of the current set bit
//   Count     out  [IW:0] ordinal of the current beat within the operand
//   Last      out  current beat is the final one for this operand
//   Empty     out  operand was all zeros
// -----------------------------------------------------------------------------
module bitscan_seq #(
  parameter  int WIDTH = 32,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic             Rev,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [IW-1:0]    Index,
  output logic [IW:0]      Count,
  output logic             Last,
  output logic             Empty
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   pending_r;
  logic [WIDTH-1:0]   pending_nxt_s;
  logic [IW:0]        count_r;
  logic [IW:0]        count_nxt_s;
  logic [IW-1:0]      index_r;
  logic [IW-1:0]      index_nxt_s;
  logic               last_r;
  logic               last_nxt_s;
  logic               empty_r;
  logic               empty_nxt_s;
  logic               accept_s;
  logic [WIDTH-1:0]   index_mask_s;

`ifdef BITSCAN_REVERSE_EN
  logic               rev_r;
  logic               rev_nxt_s;
`else
  // Rev has no function in this build; the name marks it as deliberately unused.
  logic               unused_rev_s;
  assign unused_rev_s = Rev;
`endif

  // Position of the lowest set bit; 0 when the vector is zero.
  function automatic logic [IW-1:0] lowest_set(input logic [WIDTH-1:0] v);
    logic [IW-1:0] idx;
    idx = {IW{1'b0}};
    // Scanning downward lets the lowest set bit be the final assignment.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = i[IW-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

`ifdef BITSCAN_REVERSE_EN
  // Position of the highest set bit; 0 when the vector is zero.
  function automatic logic [IW-1:0] highest_set(input logic [WIDTH-1:0] v);
    logic [IW-1:0] idx;
    idx = {IW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        idx = i[IW-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction
`endif

  // True when the vector has zero or one bit set.
  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    return ((v & (v - {{(WIDTH-1){1'b0}}, 1'b1})) == {WIDTH{1'b0}});
  endfunction

  // Handshake decode. A new operand may enter while the final beat of the
  // current one is being consumed, so OutReady feeds InReady combinationally.
  assign InReady  = (state_r == IDLE) | ((state_r == SCAN) & last_r & OutReady);
  assign OutValid = (state_r == SCAN);
  assign accept_s = InValid & InReady;

  assign index_mask_s = {{(WIDTH-1){1'b0}}, 1'b1} << index_r;

  // Next-state, next-pending and next-output computation.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    count_nxt_s   = count_r;
    empty_nxt_s   = empty_r;
`ifdef BITSCAN_REVERSE_EN
    rev_nxt_s     = rev_r;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s   = SCAN;
          pending_nxt_s = A;
          count_nxt_s   = {(IW+1){1'b0}};
          empty_nxt_s   = (A == {WIDTH{1'b0}});
`ifdef BITSCAN_REVERSE_EN
          rev_nxt_s     = Rev;
`endif
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      SCAN: begin
        if (accept_s) begin
          // Final beat consumed and a new operand taken in the same edge.
          state_nxt_s   = SCAN;
          pending_nxt_s = A;
          count_nxt_s   = {(IW+1){1'b0}};
          empty_nxt_s   = (A == {WIDTH{1'b0}});
`ifdef BITSCAN_REVERSE_EN
          rev_nxt_s     = Rev;
`endif
        end else if (OutReady && last_r) begin
          state_nxt_s   = IDLE;
          pending_nxt_s = {WIDTH{1'b0}};
          count_nxt_s   = {(IW+1){1'b0}};
          empty_nxt_s   = 1'b0;
        end else if (OutReady) begin
          pending_nxt_s = pending_r & ~index_mask_s;
          count_nxt_s   = count_r + {{IW{1'b0}}, 1'b1};
        end else begin
          state_nxt_s   = SCAN;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        pending_nxt_s = {WIDTH{1'b0}};
        count_nxt_s   = {(IW+1){1'b0}};
        empty_nxt_s   = 1'b0;
      end
    endcase

    // Index and Last are registered from the pending value they will describe,
    // so the first beat appears the cycle after acceptance with no extra stage.
    if (state_nxt_s == SCAN) begin
`ifdef BITSCAN_REVERSE_EN
      index_nxt_s = rev_nxt_s ? highest_set(pending_nxt_s) : lowest_set(pending_nxt_s);
`else
      index_nxt_s = lowest_set(pending_nxt_s);
`endif
      last_nxt_s  = at_most_one(pending_nxt_s);
    end else begin
      index_nxt_s = {IW{1'b0}};
      last_nxt_s  = 1'b0;
    end
  end

  // State, pending operand and beat output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      pending_r <= {WIDTH{1'b0}};
      count_r   <= {(IW+1){1'b0}};
      index_r   <= {IW{1'b0}};
      last_r    <= 1'b0;
      empty_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      count_r   <= count_nxt_s;
      index_r   <= index_nxt_s;
      last_r    <= last_nxt_s;
      empty_r   <= empty_nxt_s;
    end
  end

`ifdef BITSCAN_REVERSE_EN
  // Scan direction captured per operand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rev_r <= 1'b0;
    end else begin
      rev_r <= rev_nxt_s;
    end
  end
`endif

  assign Index = index_r;
  assign Count = count_r;
  assign Last  = last_r;
  assign Empty = empty_r;

endmodule

// File: tb/tb_bitscan_seq.sv
// -----------------------------------------------------------------------------
// tb_bitscan_seq
//   Self-checking bench for bitscan_seq (WIDTH=32). A directed table of
//   operands with hand-derived beat summaries, hand sequences for back-to-back
//   and mid-scan reset, and random operands; every beat is compared with a
//   reference list of set-bit positions built from the operand.
// -----------------------------------------------------------------------------
module tb_bitscan_seq;

  localparam int W  = 32;
  localparam int IW = 5;

  logic          clk;
  logic          reset;
  logic          InValid;
  logic          InReady;
  logic [W-1:0]  A;
  logic          Rev;
  logic          OutValid;
  logic          OutReady;
  logic [IW-1:0] Index;
  logic [IW:0]   Count;
  logic          Last;
  logic          Empty;

  int vectors;
  int miscompares;

  bitscan_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .A        (A),
    .Rev      (Rev),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Index    (Index),
    .Count    (Count),
    .Last     (Last),
    .Empty    (Empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic         rev;
    int           mode;      // 0: no stalls, 1: random stalls, 2: 3 stalls on first beat
    int           exp_n;
    int           exp_first;
    int           exp_final;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: ordered list of set-bit positions in scan order; a zero operand
  // yields the single position 0.
  task automatic run_op(input logic [W-1:0] a, input logic rev, input int mode,
                        output int n_obs, output int first_obs, output int final_obs);
    int   exp_q[$];
    logic eff_rev;
    int   n;
    int   stalls;
`ifdef BITSCAN_REVERSE_EN
    eff_rev = rev;
`else
    eff_rev = 1'b0;
`endif
    exp_q = {};
    for (int i = 0; i < W; i++) begin
      if (a[i]) exp_q.push_back(i);
    end
    if (eff_rev) exp_q.reverse();
    if (exp_q.size() == 0) exp_q.push_back(0);
    n = exp_q.size();
    n_obs = 0; first_obs = -1; final_obs = -1;

    @(negedge clk);
    A = a; Rev = rev; InValid = 1'b1; OutReady = 1'($urandom_range(0, 1));
    #1 chk("accept_in_ready", InReady, 1);
    @(posedge clk); #1;
    // Noise on A/Rev while scanning must not matter.
    A = $urandom; Rev = 1'($urandom_range(0, 1));
    for (int k = 0; k < n; k++) begin
      if (mode == 0) stalls = 0;
      else if (mode == 1) stalls = $urandom_range(0, 2);
      else stalls = (k == 0) ? 3 : 0;
      for (int s = 0; s <= stalls; s++) begin
        OutReady = (s == stalls);
        InValid  = (k != n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        chk("out_valid", OutValid, 1);
        chk("index", Index, exp_q[k]);
        chk("count", Count, k);
        chk("last", Last, (k == n - 1));
        chk("empty", Empty, (a == '0));
        chk("in_ready_scan", InReady, (k == n - 1) && OutReady);
        if (OutValid && OutReady) begin
          n_obs++;
          if (n_obs == 1) first_obs = int'(Index);
          final_obs = int'(Index);
        end
        @(posedge clk); #1;
      end
    end
    InValid = 1'b0; OutReady = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("idle_out_valid", OutValid, 0);
    chk("idle_in_ready", InReady, 1);
    chk("idle_index", Index, 0);
    chk("idle_count", Count, 0);
    chk("idle_last", Last, 0);
    chk("idle_empty", Empty, 0);
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    int   n_obs, f_obs, l_obs;
    logic [W-1:0] ra;
    logic [W-1:0] one;

    vectors = 0; miscompares = 0;
    reset = 1'b1; InValid = 1'b0; A = '0; Rev = 1'b0; OutReady = 1'b0;
    #2;
    chk("rst_in_ready", InReady, 1);
    chk("rst_out_valid", OutValid, 0);
    chk("rst_count", Count, 0);
    chk("rst_index", Index, 0);
    chk("rst_last", Last, 0);
    chk("rst_empty", Empty, 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    tbl.push_back('{32'h0000_0000, 1'b0, 0, 1, 0, 0});
    tbl.push_back('{32'h8000_0011, 1'b0, 0, 3, 0, 31});
`ifdef BITSCAN_REVERSE_EN
    tbl.push_back('{32'h8000_0011, 1'b1, 0, 3, 31, 0});
`else
    tbl.push_back('{32'h8000_0011, 1'b1, 0, 3, 0, 31});
`endif
    tbl.push_back('{32'h0000_0300, 1'b0, 2, 2, 8, 9});
    tbl.push_back('{32'hFFFF_FFFF, 1'b0, 1, 32, 0, 31});
    tbl.push_back('{32'h8000_0000, 1'b0, 1, 1, 31, 31});
    tbl.push_back('{32'h0000_0001, 1'b1, 1, 1, 0, 0});

    foreach (tbl[i]) begin
      v = tbl[i];
      run_op(v.a, v.rev, v.mode, n_obs, f_obs, l_obs);
      chk("tbl_beats", n_obs, v.exp_n);
      chk("tbl_first", f_obs, v.exp_first);
      chk("tbl_final", l_obs, v.exp_final);
    end

    // Back-to-back: 0x1 offered on the Last handshake of 0x2.
    @(negedge clk);
    A = 32'h2; Rev = 1'b0; InValid = 1'b1; OutReady = 1'b1;
    @(posedge clk); #1;
    A = 32'h1; InValid = 1'b1; OutReady = 1'b1;
    @(negedge clk);
    chk("b2b_first_index", Index, 1);
    chk("b2b_first_last", Last, 1);
    chk("b2b_in_ready", InReady, 1);
    @(posedge clk); #1;
    InValid = 1'b0;
    @(negedge clk);
    chk("b2b_out_valid", OutValid, 1);
    chk("b2b_index", Index, 0);
    chk("b2b_count", Count, 0);
    chk("b2b_last", Last, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b2b_idle", OutValid, 0);

    // Reset mid-scan after 5 consumed beats.
    @(negedge clk);
    A = 32'hFFFF_FFFF; InValid = 1'b1; OutReady = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_count", Count, 5);
    chk("pre_rst_index", Index, 5);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", OutValid, 0);
    chk("mid_rst_in_ready", InReady, 1);
    chk("mid_rst_count", Count, 0);
    @(negedge clk);
    reset = 1'b0;
    run_op(32'h4, 1'b0, 0, n_obs, f_obs, l_obs);
    chk("post_rst_beats", n_obs, 1);
    chk("post_rst_index", f_obs, 2);

    // Random operands with random stalls and direction.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0: ra = $urandom;
        1: ra = $urandom & $urandom & $urandom;
        2: begin one = 32'd1; ra = one << $urandom_range(0, 31); end
        default: ra = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | $urandom);
      endcase
      run_op(ra, 1'($urandom_range(0, 1)), 1, n_obs, f_obs, l_obs);
      chk("rnd_beats", n_obs, (ra == '0) ? 1 : $countones(ra));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
